// File: rtl/logs_iterate_map_mc.sv
// logs_iterate_map_mc: round-robin multi-channel logistic-map iterator.
// Computes x <- r*x*(1-x) for every channel on one shared shift-and-add
// multiplier and streams (channel, x) samples out over valid/ready.
module logs_iterate_map_mc #(
    parameter int unsigned FRAC     = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned ITER_LEN = 0,
    parameter int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS*(FRAC+2)-1:0] r_in,
    input  logic [FRAC-1:0]              x0,
    input  logic [7:0]                   burn_in,
    input  logic                         start,
    input  logic                         stop,
    output logic                         busy,
    output logic [FRAC-1:0]              x_out,
    output logic [CH_W-1:0]              x_chan,
    output logic                         x_valid,
    input  logic                         x_ready
);
    localparam int unsigned AW    = 2*FRAC + 2;
    localparam int unsigned BASE  = 2*FRAC + 3;
    localparam int unsigned L     = (ITER_LEN > BASE) ? ITER_LEN : BASE;
    localparam int unsigned PAD_N = L - BASE;
    localparam int unsigned CNT_W = $clog2(FRAC);

    typedef enum logic [2:0] {
        StIdle, StLoad, StMul1, StXfer, StMul2, StWb, StPad
    } state_e;

    state_e          state_q;
    logic [FRAC+1:0] r_q [CHANNELS];
    logic [FRAC-1:0] x_q [CHANNELS];
    logic [7:0]      burn_q;
    logic [7:0]      round_q;
    logic [CH_W-1:0] ch_q;
    logic            stop_q;
    logic [AW-1:0]   mult1_q;
    logic [AW-1:0]   accum_q;
    logic [FRAC-1:0] mult2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]     pad_q;
    logic [FRAC-1:0] x_out_q;
    logic [CH_W-1:0] x_chan_q;
    logic            x_valid_q;

    logic [AW-1:0]   step_acc;
    logic [FRAC-1:0] xn;
    logic            due;
    logic            hold;
    logic            last_ch;
    logic [CH_W-1:0] ch_nxt;
    logic [7:0]      round_nxt;
    state_e          adv_state;

    // Multiplier step, truncated product, and round-robin advance values.
    always_comb begin
        step_acc  = mult2_q[0] ? accum_q + mult1_q : accum_q;
        xn        = accum_q[2*FRAC-1:FRAC];
        due       = (round_q >= burn_q);
        // Output due but the slot is still occupied and not draining this cycle.
        hold      = due && x_valid_q && !x_ready;
        last_ch   = (ch_q == CH_W'(CHANNELS - 1));
        ch_nxt    = last_ch ? '0 : ch_q + 1'b1;
        round_nxt = (last_ch && round_q != 8'hFF) ? round_q + 8'd1 : round_q;
        adv_state = stop_q ? StIdle : StLoad;
    end

    // Control FSM, datapath and registered output slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            burn_q    <= '0;
            round_q   <= '0;
            ch_q      <= '0;
            stop_q    <= 1'b0;
            mult1_q   <= '0;
            mult2_q   <= '0;
            accum_q   <= '0;
            cnt_q     <= '0;
            pad_q     <= '0;
            x_out_q   <= '0;
            x_chan_q  <= '0;
            x_valid_q <= 1'b0;
            for (int k = 0; k < int'(CHANNELS); k++) begin
                r_q[k] <= '0;
                x_q[k] <= '0;
            end
        end else begin
            if (x_valid_q && x_ready) x_valid_q <= 1'b0;
            if (state_q != StIdle && stop) stop_q <= 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        for (int k = 0; k < int'(CHANNELS); k++) begin
                            r_q[k] <= r_in[k*(FRAC+2) +: FRAC+2];
                            x_q[k] <= x0;
                        end
                        burn_q  <= burn_in;
                        ch_q    <= '0;
                        round_q <= '0;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    mult1_q <= AW'(x_q[ch_q]);
                    mult2_q <= ~x_q[ch_q];
                    accum_q <= '0;
                    cnt_q   <= '0;
                    state_q <= StMul1;
                end
                StMul1, StMul2: begin
                    accum_q <= step_acc;
                    mult1_q <= mult1_q << 1;
                    mult2_q <= mult2_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(FRAC - 1)) begin
                        state_q <= (state_q == StMul1) ? StXfer : StWb;
                    end
                end
                StXfer: begin
                    mult1_q <= AW'(r_q[ch_q]);
                    mult2_q <= accum_q[2*FRAC-1:FRAC];
                    accum_q <= '0;
                    cnt_q   <= '0;
                    state_q <= StMul2;
                end
                StWb: begin
                    if (!hold) begin
                        x_q[ch_q] <= xn;
                        if (due) begin
                            x_out_q   <= xn;
                            x_chan_q  <= ch_q;
                            x_valid_q <= 1'b1;
                        end
                        if (PAD_N == 0) begin
                            ch_q    <= ch_nxt;
                            round_q <= round_nxt;
                            state_q <= adv_state;
                            if (stop_q) stop_q <= 1'b0;
                        end else begin
                            pad_q   <= '0;
                            state_q <= StPad;
                        end
                    end
                end
                StPad: begin
                    if (pad_q == 16'(PAD_N - 1)) begin
                        ch_q    <= ch_nxt;
                        round_q <= round_nxt;
                        state_q <= adv_state;
                        if (stop_q) stop_q <= 1'b0;
                    end else begin
                        pad_q <= pad_q + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy    = (state_q != StIdle);
    assign x_out   = x_out_q;
    assign x_chan  = x_chan_q;
    assign x_valid = x_valid_q;

endmodule

// File: tb/tb_logs_iterate_map_mc.sv
// Self-checking bench for logs_iterate_map_mc (FRAC=8): a 4-channel and a
// 1-channel instance, table-driven runs plus stall/stop/reset sequences.
module tb_logs_iterate_map_mc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, stop, x_ready;
    logic [7:0]  x0, burn;
    logic [39:0] r4;
    logic [9:0]  r1;
    logic        busy4, xv4, busy1, xv1;
    logic [7:0]  xo4, xo1;
    logic [1:0]  xc4;
    logic [0:0]  xc1;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int got_n  = 0;
    logic [7:0] got_x [8];
    int         got_c [8];
    int         got_t [8];

    logs_iterate_map_mc #(.FRAC(8), .CHANNELS(4), .ITER_LEN(0)) dut4 (
        .clk(clk), .reset(reset), .r_in(r4), .x0(x0), .burn_in(burn),
        .start(start), .stop(stop), .busy(busy4), .x_out(xo4), .x_chan(xc4),
        .x_valid(xv4), .x_ready(x_ready)
    );

    logs_iterate_map_mc #(.FRAC(8), .CHANNELS(1), .ITER_LEN(0)) dut1 (
        .clk(clk), .reset(reset), .r_in(r1), .x0(x0), .burn_in(burn),
        .start(start), .stop(stop), .busy(busy1), .x_out(xo1), .x_chan(xc1),
        .x_valid(xv1), .x_ready(x_ready)
    );

    typedef struct {
        logic [39:0]      r;
        logic [7:0]       x0;
        logic [7:0]       burn;
        int               first;
        logic [0:5][7:0]  ex;
    } vec_t;
    vec_t vt [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
    endtask

    // Record accepted samples (valid && ready at the sampling point) with their cycle.
    task automatic collect(input bit one, input int n, input int budget);
        got_n = 0;
        for (int k = 0; k < budget && got_n < n; k++) begin
            tick();
            cyc++;
            if (one ? (xv1 && x_ready) : (xv4 && x_ready)) begin
                got_x[got_n] = one ? xo1 : xo4;
                got_c[got_n] = one ? int'(xc1) : int'(xc4);
                got_t[got_n] = cyc;
                got_n++;
            end
        end
        n_cmp++;
        if (got_n != n) begin
            n_fail++;
            $display("FAIL collect: got %0d samples, required %0d", got_n, n);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; x_ready = 1'b1;
        x0 = 8'h10; burn = 8'd0; r4 = '0; r1 = 10'h300;

        vt[0] = '{r: {10'h300, 10'h000, 10'h300, 10'h300}, x0: 8'h10, burn: 8'd0, first: 19,
                  ex: {8'h2A, 8'h2A, 8'h00, 8'h2A, 8'h66, 8'h66}};
        vt[1] = '{r: {10'h300, 10'h000, 10'h300, 10'h300}, x0: 8'h10, burn: 8'd2, first: 171,
                  ex: {8'hB4, 8'hB4, 8'h00, 8'hB4, 8'h9C, 8'h9C}};
        vt[2] = '{r: {10'h000, 10'h3FF, 10'h100, 10'h200}, x0: 8'h80, burn: 8'd0, first: 19,
                  ex: {8'h7E, 8'h3F, 8'hFB, 8'h00, 8'h7E, 8'h2F}};
        vt[3] = '{r: {10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF}, x0: 8'h00, burn: 8'd1, first: 95,
                  ex: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vt[4] = '{r: {10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF}, x0: 8'hFF, burn: 8'd0, first: 19,
                  ex: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};

        // Reset state.
        tick();
        chk("rst_busy", 32'(busy4), 0);
        chk("rst_valid", 32'(xv4), 0);
        chk("rst_xout", 32'(xo4), 0);
        chk("rst_xchan", 32'(xc4), 0);
        reset = 1'b0;
        tick();
        chk("idle_busy", 32'(busy4), 0);

        // Single-channel instance: 0x2A at edge 19, 0x66 exactly 19 later.
        do_reset();
        x0 = 8'h10; burn = 8'd0; r1 = 10'h300; x_ready = 1'b1;
        pulse_start();
        collect(1'b1, 2, 80);
        chk("c1_x0", 32'(got_x[0]), 32'h2A);
        chk("c1_t0", 32'(got_t[0]), 19);
        chk("c1_ch0", 32'(got_c[0]), 0);
        chk("c1_x1", 32'(got_x[1]), 32'h66);
        chk("c1_t1", 32'(got_t[1]), 38);

        // Table-driven four-channel runs with free-flowing output.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            r4 = vt[i].r; x0 = vt[i].x0; burn = vt[i].burn; x_ready = 1'b1;
            pulse_start();
            collect(1'b0, 6, vt[i].first + 19*6 + 40);
            for (int j = 0; j < 6; j++) begin
                chk($sformatf("v%0d_x%0d", i, j), 32'(got_x[j]), 32'(vt[i].ex[j]));
                chk($sformatf("v%0d_ch%0d", i, j), 32'(got_c[j]), 32'(j % 4));
                chk($sformatf("v%0d_t%0d", i, j), 32'(got_t[j]), 32'(vt[i].first + 19*j));
            end
        end

        // Backpressure: hold the first sample for 50 cycles, then drain.
        do_reset();
        r4 = vt[0].r; x0 = 8'h10; burn = 8'd0; x_ready = 1'b1;
        pulse_start();
        collect(1'b0, 1, 60);
        chk("bp_first_x", 32'(got_x[0]), 32'h2A);
        x_ready = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            chk("bp_valid", 32'(xv4), 1);
            chk("bp_xout", 32'(xo4), 32'h2A);
            chk("bp_xchan", 32'(xc4), 0);
            chk("bp_busy", 32'(busy4), 1);
        end
        x_ready = 1'b1;
        collect(1'b0, 4, 120);
        chk("bp_x1", 32'(got_x[0]), 32'h2A);
        chk("bp_c1", 32'(got_c[0]), 1);
        chk("bp_x2", 32'(got_x[1]), 32'h00);
        chk("bp_c2", 32'(got_c[1]), 2);
        chk("bp_x3", 32'(got_x[2]), 32'h2A);
        chk("bp_c3", 32'(got_c[2]), 3);
        chk("bp_x4", 32'(got_x[3]), 32'h66);
        chk("bp_c4", 32'(got_c[3]), 0);

        // Stop (with a simultaneous ignored start) during ch1 MUL1.
        do_reset();
        r4 = vt[0].r; x0 = 8'h10; burn = 8'd0; x_ready = 1'b1;
        pulse_start();
        while (cyc < 23) begin
            tick();
            cyc++;
        end
        stop = 1'b1; start = 1'b1;
        tick();
        cyc++;
        stop = 1'b0; start = 1'b0;
        collect(1'b0, 1, 40);
        chk("stop_c1", 32'(got_c[0]), 1);
        chk("stop_x1", 32'(got_x[0]), 32'h2A);
        chk("stop_t1", 32'(got_t[0]), 38);
        chk("stop_busy", 32'(busy4), 0);
        for (int k = 0; k < 40; k++) tick();
        chk("stop_drained", 32'(xv4), 0);
        chk("stop_idle", 32'(busy4), 0);

        // Start and stop together in IDLE: start wins, run continues past ch0.
        stop = 1'b1;
        pulse_start();
        stop = 1'b0;
        collect(1'b0, 2, 80);
        chk("ss_c0", 32'(got_c[0]), 0);
        chk("ss_t0", 32'(got_t[0]), 19);
        chk("ss_c1", 32'(got_c[1]), 1);
        chk("ss_t1", 32'(got_t[1]), 38);
        chk("ss_busy", 32'(busy4), 1);

        // Asynchronous reset mid-MUL2 of ch1 with a held sample.
        do_reset();
        r4 = vt[0].r; x0 = 8'h10; burn = 8'd0; x_ready = 1'b0;
        pulse_start();
        while (cyc < 33) begin
            tick();
            cyc++;
        end
        chk("ar_pre_valid", 32'(xv4), 1);
        #3 reset = 1'b1;
        #1;
        chk("ar_valid", 32'(xv4), 0);
        chk("ar_busy", 32'(busy4), 0);
        chk("ar_xout", 32'(xo4), 0);
        tick();
        reset = 1'b0; x_ready = 1'b1;
        tick();
        pulse_start();
        collect(1'b0, 2, 80);
        chk("ar_x0", 32'(got_x[0]), 32'h2A);
        chk("ar_t0", 32'(got_t[0]), 19);
        chk("ar_x1", 32'(got_x[1]), 32'h2A);
        chk("ar_c1", 32'(got_c[1]), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/logs_iterate_map_mc.md
Name: logs_iterate_map_mc

Overview:
Multi-channel successor to the logistic-map iterator. Iterates x <- r*x*(1-x) for CHANNELS independent r values on a single shared shift-and-add multiplier, serving the channels round-robin. Adds a start/stop control, a programmable seed, a burn-in count that discards transient iterations, and a valid/ready output stream tagged with the channel number. Feeds the display/sonification path, which consumes one (channel, x) sample at a time.

Parameters:
FRAC, 8, fraction bits. x is 0.FRAC fixed-point, r is 2.FRAC. FRAC >= 4.
CHANNELS, 4, number of independent maps (>= 1).
ITER_LEN, 0, minimum cycles per channel-iteration. The effective length is L = max(ITER_LEN, 2*FRAC+3).
CH_W, max(1,$clog2(CHANNELS)), width of the channel tag.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
r_in  in  CHANNELS*(FRAC+2)  packed r values; channel k occupies bits [k*(FRAC+2) +: FRAC+2]
x0  in  FRAC  seed loaded into every channel on start
burn_in  in  8  number of full rounds to discard after start
start  in  1  begin a run (sampled only in IDLE)
stop  in  1  end the run after the current channel-iteration
busy  out  1  high in any state other than IDLE
x_out  out  FRAC  result sample
x_chan  out  CH_W  channel of x_out
x_valid  out  1  x_out/x_chan valid
x_ready  in  1  consumer accepts the sample when x_valid && x_ready

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, busy=0, x_valid=0, x_out=0, x_chan=0, all channel x registers=0, round counter=0, stop latch=0. Reset mid-run aborts the run with no further output.
- States:
  - IDLE -> LOAD on start. The start edge latches r_in and burn_in into internal registers, sets every channel x to x0, sets ch=0 and round=0.
  - LOAD (1 cycle): mult1=x[ch] zero-extended to 2*FRAC+2 bits; mult2=~x[ch] (this is 1-x); accum=0.
  - MUL1 (FRAC cycles): if mult2[0], accum+=mult1; mult1<<=1; mult2>>=1.
  - XFER (1 cycle): t=accum[2FRAC-1:FRAC]; mult1=r[ch] zero-extended; mult2=t; accum=0.
  - MUL2 (FRAC cycles): same step as MUL1.
  - WB (1 cycle): xn=accum[2FRAC-1:FRAC], truncated with no rounding; bits above 2FRAC-1 are discarded.
  - PAD: L-(2FRAC+3) idle cycles, then advance.
- WB commit: the commit writes x[ch]=xn. If round >= burn_in, it also loads x_out=xn, x_chan=ch and x_valid=1.
- WB stall: if an output is due and x_valid=1 with x_ready=0, hold in WB. No state changes while held, and the held x_out/x_chan stay stable. The commit occurs on the first edge where the slot is free, or is freed the same cycle by x_valid&&x_ready.
- Output slot: x_valid clears on x_ready unless a new commit refills it the same edge.
- Advance after WB/PAD:
  - ch wraps CHANNELS-1 -> 0.
  - round increments when ch wraps, saturating at 255.
  - If the stop latch is set, go to IDLE; otherwise go to LOAD.
- stop is latched any cycle while busy, and cleared on entering IDLE. stop in IDLE is ignored. start while busy is ignored. start and stop together in IDLE: start wins, stop is ignored.
- A pending x_valid survives the return to IDLE and is drained normally.
- Latency: start sampled at edge E0 -> first commit at edge E0+2FRAC+3 (19 for FRAC=8) when burn_in=0. Steady-state throughput is one sample per L cycles without backpressure.
- CHANNELS=1: ch stays 0, x_chan=0. r=0 gives xn=0. x0=0 stays 0.

Test Plan:
- FRAC=8, CHANNELS=1, r=0x300 (3.0), x0=0x10, burn_in=0, x_ready=1, start pulse -> x_valid at edge 19 with x_out=0x2A, x_chan=0; next sample 0x66 exactly 19 cycles later.
- CHANNELS=4, r={ch3=0x300, ch2=0x000, ch1=0x300, ch0=0x300}, x0=0x10 -> samples tagged 0,1,2,3 in order with values 0x2A,0x2A,0x00,0x2A; second round gives 0x66 on ch0.
- burn_in=2, CHANNELS=4 -> first 8 channel-iterations produce no x_valid; first sample is ch0 round-3 value (third iterate).
- x_ready=0 for 50 cycles after the first sample -> x_valid and x_out stay stable and busy=1; the engine stalls in WB; after x_ready=1, samples resume with no loss or duplication.
- stop asserted mid-MUL1 of ch1 -> ch1 result still committed, then IDLE (busy=0); start asserted in the same cycle as stop while busy is ignored.
- reset asserted asynchronously mid-MUL2 (between edges) -> x_valid, busy, x_out drop to 0 immediately; a new start afterwards reproduces the first scenario exactly.
